// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit bus CPU control path.
// Holds opcodes, sequencer state encoding and control-word bit positions.
// Both the sequencer RTL and its bench use these so strobe ordering stays in one place.
package cpu_pkg;

    // Widths of the decoded opcode and the step debug field
    localparam int OP_W      = 4;
    localparam int STEP_BITS = 3;

    // Instruction set, IR[7:4]
    localparam logic [OP_W-1:0] OP_NOP = 4'h0;
    localparam logic [OP_W-1:0] OP_LDA = 4'h1;
    localparam logic [OP_W-1:0] OP_ADD = 4'h2;
    localparam logic [OP_W-1:0] OP_SUB = 4'h3;
    localparam logic [OP_W-1:0] OP_STA = 4'h4;
    localparam logic [OP_W-1:0] OP_LDI = 4'h5;
    localparam logic [OP_W-1:0] OP_JMP = 4'h6;
    localparam logic [OP_W-1:0] OP_JC  = 4'h7;
    localparam logic [OP_W-1:0] OP_JZ  = 4'h8;
    localparam logic [OP_W-1:0] OP_OUT = 4'hE;
    localparam logic [OP_W-1:0] OP_HLT = 4'hF;

    // Sequencer T-states; T0..T4 encode their own step index
    typedef enum logic [2:0] {
        ST_T0   = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T3   = 3'd3,
        ST_T4   = 3'd4,
        ST_HALT = 3'd5
    } state_t;

    // Control-word bit positions
    localparam int CW_PC_OUT     = 0;
    localparam int CW_PC_INC     = 1;
    localparam int CW_PC_LOAD    = 2;
    localparam int CW_MAR_LOAD   = 3;
    localparam int CW_RAM_OUT    = 4;
    localparam int CW_RAM_LOAD   = 5;
    localparam int CW_IR_LOAD    = 6;
    localparam int CW_IR_OUT     = 7;
    localparam int CW_A_LOAD     = 8;
    localparam int CW_A_OUT      = 9;
    localparam int CW_B_LOAD     = 10;
    localparam int CW_ALU_OUT    = 11;
    localparam int CW_ALU_SUB    = 12;
    localparam int CW_FLAGS_LOAD = 13;
    localparam int CW_OUT_LOAD   = 14;
    localparam int CW_W          = 15;

    typedef logic [CW_W-1:0] cw_t;

    // Single-bit control-word mask for a strobe index
    function automatic cw_t cw_bit(input int idx);
        cw_t m;
        m = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

    // The strobes that put a value on the shared bus
    function automatic cw_t bus_drivers(input cw_t cw);
        cw_t m;
        m = cw_bit(CW_PC_OUT) | cw_bit(CW_RAM_OUT) | cw_bit(CW_IR_OUT) |
            cw_bit(CW_A_OUT)  | cw_bit(CW_ALU_OUT);
        return cw & m;
    endfunction

endpackage

// File: rtl/microcode_rom.sv
// Microcode decode: (state, opcode, cf, zf) -> control word, end-of-instruction, halt request.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the sequencer gates the word with ena/reset/halt.
module microcode_rom
    import cpu_pkg::*;
(
    input  state_t            state,
    input  logic [OP_W-1:0]   opcode,
    input  logic              cf,
    input  logic              zf,
    output cw_t               cw,
    output logic              last,
    output logic              hlt
);

    // Per-step strobe decode; fetch steps ignore the opcode, execute steps follow it
    always_comb begin
        cw   = '0;
        last = 1'b0;
        hlt  = 1'b0;
        case (state)
            ST_T0: begin
                cw[CW_PC_OUT]   = 1'b1;
                cw[CW_MAR_LOAD] = 1'b1;
            end
            ST_T1: begin
                cw[CW_RAM_OUT] = 1'b1;
                cw[CW_IR_LOAD] = 1'b1;
                cw[CW_PC_INC]  = 1'b1;
            end
            ST_T2: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        cw[CW_IR_OUT]   = 1'b1;
                        cw[CW_MAR_LOAD] = 1'b1;
                    end
                    OP_LDI: begin
                        cw[CW_IR_OUT] = 1'b1;
                        cw[CW_A_LOAD] = 1'b1;
                        last          = 1'b1;
                    end
                    OP_JMP: begin
                        cw[CW_IR_OUT]  = 1'b1;
                        cw[CW_PC_LOAD] = 1'b1;
                        last           = 1'b1;
                    end
                    OP_JC: begin
                        cw[CW_IR_OUT]  = cf;
                        cw[CW_PC_LOAD] = cf;
                        last           = 1'b1;
                    end
                    OP_JZ: begin
                        cw[CW_IR_OUT]  = zf;
                        cw[CW_PC_LOAD] = zf;
                        last           = 1'b1;
                    end
                    OP_OUT: begin
                        cw[CW_A_OUT]    = 1'b1;
                        cw[CW_OUT_LOAD] = 1'b1;
                        last            = 1'b1;
                    end
                    OP_HLT: begin
                        hlt = 1'b1;
                    end
                    // NOP and the unassigned codes 0x9..0xD do nothing for one step
                    default: begin
                        last = 1'b1;
                    end
                endcase
            end
            ST_T3: begin
                case (opcode)
                    OP_LDA: begin
                        cw[CW_RAM_OUT] = 1'b1;
                        cw[CW_A_LOAD]  = 1'b1;
                        last           = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        cw[CW_RAM_OUT] = 1'b1;
                        cw[CW_B_LOAD]  = 1'b1;
                        cw[CW_ALU_SUB] = (opcode == OP_SUB);
                    end
                    OP_STA: begin
                        cw[CW_A_OUT]    = 1'b1;
                        cw[CW_RAM_LOAD] = 1'b1;
                        last            = 1'b1;
                    end
                    // Opcode changed under us: bail back to fetch rather than stall
                    default: begin
                        last = 1'b1;
                    end
                endcase
            end
            ST_T4: begin
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    cw[CW_ALU_OUT]    = 1'b1;
                    cw[CW_A_LOAD]     = 1'b1;
                    cw[CW_FLAGS_LOAD] = 1'b1;
                    cw[CW_ALU_SUB]    = (opcode == OP_SUB);
                end
                last = 1'b1;
            end
            default: begin
                cw = '0;
            end
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/execute T-state sequencer issuing bus load/output strobes to the datapath.
// Latency: strobes are combinational from the registered step; one T-state per enabled clock.
// Backpressure: ena=0 holds the step and zeroes all strobes; HALT holds until rst.
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int STEP_W   = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                cf,
    input  logic                zf,
    output logic                pc_out,
    output logic                pc_inc,
    output logic                pc_load,
    output logic                mar_load,
    output logic                ram_out,
    output logic                ram_load,
    output logic                ir_load,
    output logic                ir_out,
    output logic                a_load,
    output logic                a_out,
    output logic                b_load,
    output logic                alu_out,
    output logic                alu_sub,
    output logic                flags_load,
    output logic                out_load,
    output logic                halted,
    output logic [STEP_W-1:0]   step
);

    state_t          state;
    state_t          state_nxt;
    logic [OP_W-1:0] op_nib;
    cw_t             rom_cw;
    logic            rom_last;
    logic            rom_hlt;
    logic            run;
    cw_t             cw;

    assign op_nib = OP_W'(opcode);

    microcode_rom u_rom (
        .state  (state),
        .opcode (op_nib),
        .cf     (cf),
        .zf     (zf),
        .cw     (rom_cw),
        .last   (rom_last),
        .hlt    (rom_hlt)
    );

    // State register; reset wins over ena, HALT and any mid-instruction step
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_T0;
        end else begin
            state <= state_nxt;
        end
    end

    // Next step: advance only when enabled, wrap on end-of-instruction, trap on HLT
    always_comb begin
        state_nxt = state;
        if (state != ST_HALT && ena) begin
            if (rom_hlt) begin
                state_nxt = ST_HALT;
            end else if (rom_last) begin
                state_nxt = ST_T0;
            end else begin
                state_nxt = state_t'(3'(state) + 3'd1);
            end
        end
    end

    // Strobes only fire in a live, enabled, non-reset cycle
    assign run = ena && !rst && (state != ST_HALT);
    assign cw  = run ? rom_cw : '0;

    assign pc_out     = cw[CW_PC_OUT];
    assign pc_inc     = cw[CW_PC_INC];
    assign pc_load    = cw[CW_PC_LOAD];
    assign mar_load   = cw[CW_MAR_LOAD];
    assign ram_out    = cw[CW_RAM_OUT];
    assign ram_load   = cw[CW_RAM_LOAD];
    assign ir_load    = cw[CW_IR_LOAD];
    assign ir_out     = cw[CW_IR_OUT];
    assign a_load     = cw[CW_A_LOAD];
    assign a_out      = cw[CW_A_OUT];
    assign b_load     = cw[CW_B_LOAD];
    assign alu_out    = cw[CW_ALU_OUT];
    assign alu_sub    = cw[CW_ALU_SUB];
    assign flags_load = cw[CW_FLAGS_LOAD];
    assign out_load   = cw[CW_OUT_LOAD];

    assign halted = (state == ST_HALT);
    assign step   = (state == ST_HALT) ? STEP_W'(4) : STEP_W'(3'(state));

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       rst, ena, cf, zf;
    logic [3:0] opcode;
    logic       pc_out, pc_inc, pc_load, mar_load, ram_out, ram_load, ir_load, ir_out;
    logic       a_load, a_out, b_load, alu_out, alu_sub, flags_load, out_load, halted;
    logic [2:0] step;

    int n_vec = 0;
    int n_bad = 0;

    control_sequencer #(.OPCODE_W(4), .STEP_W(3)) dut (
        .clk(clk), .rst(rst), .ena(ena), .opcode(opcode), .cf(cf), .zf(zf),
        .pc_out(pc_out), .pc_inc(pc_inc), .pc_load(pc_load), .mar_load(mar_load),
        .ram_out(ram_out), .ram_load(ram_load), .ir_load(ir_load), .ir_out(ir_out),
        .a_load(a_load), .a_out(a_out), .b_load(b_load), .alu_out(alu_out),
        .alu_sub(alu_sub), .flags_load(flags_load), .out_load(out_load),
        .halted(halted), .step(step)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       ena;
        logic [3:0] op;
        logic       cf;
        logic       zf;
        cw_t        cw;
        logic [2:0] step;
        logic       halted;
    } vec_t;

    vec_t vt[$];

    // Named strobe masks
    cw_t M_PCO, M_PCI, M_PCL, M_MAR, M_RAMO, M_RAML, M_IRL, M_IRO;
    cw_t M_AL, M_AO, M_BL, M_ALUO, M_SUB, M_FL, M_OUTL, F_T0, F_T1;

    function automatic cw_t dut_cw();
        cw_t c;
        c = '0;
        c[CW_PC_OUT] = pc_out;      c[CW_PC_INC] = pc_inc;       c[CW_PC_LOAD] = pc_load;
        c[CW_MAR_LOAD] = mar_load;  c[CW_RAM_OUT] = ram_out;     c[CW_RAM_LOAD] = ram_load;
        c[CW_IR_LOAD] = ir_load;    c[CW_IR_OUT] = ir_out;       c[CW_A_LOAD] = a_load;
        c[CW_A_OUT] = a_out;        c[CW_B_LOAD] = b_load;       c[CW_ALU_OUT] = alu_out;
        c[CW_ALU_SUB] = alu_sub;    c[CW_FLAGS_LOAD] = flags_load; c[CW_OUT_LOAD] = out_load;
        return c;
    endfunction

    task automatic add(input logic r, input logic e, input logic [3:0] op, input logic c,
                       input logic z, input cw_t ecw, input logic [2:0] est, input logic eh);
        vec_t v;
        v.rst = r; v.ena = e; v.op = op; v.cf = c; v.zf = z;
        v.cw = ecw; v.step = est; v.halted = eh;
        vt.push_back(v);
    endtask

    task automatic apply(input logic r, input logic e, input logic [3:0] op,
                         input logic c, input logic z);
        @(posedge clk);
        #1;
        rst = r; ena = e; opcode = op; cf = c; zf = z;
        @(negedge clk);
    endtask

    task automatic check(input string name, input cw_t ecw, input logic [2:0] est,
                         input logic eh);
        cw_t got;
        got = dut_cw();
        n_vec++;
        if (got !== ecw || step !== est || halted !== eh) begin
            n_bad++;
            $display("FAIL %s: got cw=%h step=%0d halted=%0b, expected cw=%h step=%0d halted=%0b",
                     name, got, step, halted, ecw, est, eh);
        end
    endtask

    task automatic check_onehot(input string name);
        int drv;
        drv = int'(pc_out) + int'(ram_out) + int'(ir_out) + int'(a_out) + int'(alu_out);
        n_vec++;
        if (drv > 1) begin
            n_bad++;
            $display("FAIL %s: %0d bus drivers active, expected at most 1", name, drv);
        end
    endtask

    // Reference: instruction length in T-states, from the instruction table
    function automatic int ins_len(input logic [3:0] op);
        case (op)
            4'h1, 4'h4: return 4;
            4'h2, 4'h3: return 5;
            default:    return 3;
        endcase
    endfunction

    // Reference: strobes for step t of instruction op
    function automatic cw_t ref_mask(input logic [3:0] op, input int t, input logic c,
                                     input logic z);
        if (t == 0) return F_T0;
        if (t == 1) return F_T1;
        case (op)
            4'h1: return (t == 2) ? (M_IRO | M_MAR) : (M_RAMO | M_AL);
            4'h2: return (t == 2) ? (M_IRO | M_MAR) : (t == 3) ? (M_RAMO | M_BL)
                                                               : (M_ALUO | M_AL | M_FL);
            4'h3: return (t == 2) ? (M_IRO | M_MAR) : (t == 3) ? (M_RAMO | M_BL | M_SUB)
                                                               : (M_ALUO | M_AL | M_FL | M_SUB);
            4'h4: return (t == 2) ? (M_IRO | M_MAR) : (M_AO | M_RAML);
            4'h5: return M_IRO | M_AL;
            4'h6: return M_IRO | M_PCL;
            4'h7: return c ? (M_IRO | M_PCL) : '0;
            4'h8: return z ? (M_IRO | M_PCL) : '0;
            4'hE: return M_AO | M_OUTL;
            default: return '0;
        endcase
    endfunction

    initial begin
        M_PCO = cw_bit(CW_PC_OUT);   M_PCI = cw_bit(CW_PC_INC);   M_PCL = cw_bit(CW_PC_LOAD);
        M_MAR = cw_bit(CW_MAR_LOAD); M_RAMO = cw_bit(CW_RAM_OUT); M_RAML = cw_bit(CW_RAM_LOAD);
        M_IRL = cw_bit(CW_IR_LOAD);  M_IRO = cw_bit(CW_IR_OUT);   M_AL = cw_bit(CW_A_LOAD);
        M_AO = cw_bit(CW_A_OUT);     M_BL = cw_bit(CW_B_LOAD);    M_ALUO = cw_bit(CW_ALU_OUT);
        M_SUB = cw_bit(CW_ALU_SUB);  M_FL = cw_bit(CW_FLAGS_LOAD); M_OUTL = cw_bit(CW_OUT_LOAD);
        F_T0 = M_PCO | M_MAR;
        F_T1 = M_RAMO | M_IRL | M_PCI;

        rst = 1'b1; ena = 1'b0; opcode = 4'h0; cf = 1'b0; zf = 1'b0;

        // Directed table: one row per cycle (rst, ena, op, cf, zf | cw, step, halted)
        add(1, 1, 4'h1, 0, 0, '0, 0, 0);                          // reset cycle
        add(0, 1, 4'h1, 0, 0, F_T0, 0, 0);                        // LDA
        add(0, 1, 4'h1, 0, 0, F_T1, 1, 0);
        add(0, 1, 4'h1, 0, 0, M_IRO | M_MAR, 2, 0);
        add(0, 1, 4'h1, 0, 0, M_RAMO | M_AL, 3, 0);
        add(0, 1, 4'h3, 0, 0, F_T0, 0, 0);                        // SUB
        add(0, 1, 4'h3, 0, 0, F_T1, 1, 0);
        add(0, 1, 4'h3, 0, 0, M_IRO | M_MAR, 2, 0);
        add(0, 1, 4'h3, 0, 0, M_RAMO | M_BL | M_SUB, 3, 0);
        add(0, 1, 4'h3, 0, 0, M_ALUO | M_AL | M_FL | M_SUB, 4, 0);
        add(0, 1, 4'h7, 0, 1, F_T0, 0, 0);                        // JC, not taken
        add(0, 1, 4'h7, 0, 1, F_T1, 1, 0);
        add(0, 1, 4'h7, 0, 1, '0, 2, 0);
        add(0, 1, 4'h7, 1, 0, F_T0, 0, 0);                        // JC, taken
        add(0, 1, 4'h7, 1, 0, F_T1, 1, 0);
        add(0, 1, 4'h7, 1, 0, M_IRO | M_PCL, 2, 0);
        add(0, 1, 4'h8, 1, 0, F_T0, 0, 0);                        // JZ, not taken
        add(0, 1, 4'h8, 1, 0, F_T1, 1, 0);
        add(0, 1, 4'h8, 1, 0, '0, 2, 0);
        add(0, 1, 4'h8, 0, 1, F_T0, 0, 0);                        // JZ, taken
        add(0, 1, 4'h8, 0, 1, F_T1, 1, 0);
        add(0, 1, 4'h8, 0, 1, M_IRO | M_PCL, 2, 0);
        add(0, 1, 4'hE, 0, 0, F_T0, 0, 0);                        // OUT
        add(0, 1, 4'hE, 0, 0, F_T1, 1, 0);
        add(0, 1, 4'hE, 0, 0, M_AO | M_OUTL, 2, 0);
        add(0, 1, 4'h2, 0, 0, F_T0, 0, 0);                        // ADD with stall at T3
        add(0, 1, 4'h2, 0, 0, F_T1, 1, 0);
        add(0, 1, 4'h2, 0, 0, M_IRO | M_MAR, 2, 0);
        add(0, 0, 4'h2, 0, 0, '0, 3, 0);
        add(0, 0, 4'h2, 0, 0, '0, 3, 0);
        add(0, 0, 4'h2, 0, 0, '0, 3, 0);
        add(0, 1, 4'h2, 0, 0, M_RAMO | M_BL, 3, 0);
        add(0, 1, 4'h2, 0, 0, M_ALUO | M_AL | M_FL, 4, 0);
        add(0, 1, 4'h1, 0, 0, F_T0, 0, 0);                        // LDA cut by reset at T3
        add(0, 1, 4'h1, 0, 0, F_T1, 1, 0);
        add(0, 1, 4'h1, 0, 0, M_IRO | M_MAR, 2, 0);
        add(1, 1, 4'h1, 0, 0, '0, 3, 0);
        add(0, 1, 4'hA, 0, 0, F_T0, 0, 0);                        // undefined opcode
        add(0, 1, 4'hA, 0, 0, F_T1, 1, 0);
        add(0, 1, 4'hA, 0, 0, '0, 2, 0);
        add(0, 1, 4'hF, 0, 0, F_T0, 0, 0);                        // HLT
        add(0, 1, 4'hF, 0, 0, F_T1, 1, 0);
        add(0, 1, 4'hF, 1, 1, '0, 2, 0);
        add(0, 1, 4'hF, 0, 0, '0, 4, 1);

        @(posedge clk);   // settle the reset state before the table starts

        for (int i = 0; i < vt.size(); i++) begin
            apply(vt[i].rst, vt[i].ena, vt[i].op, vt[i].cf, vt[i].zf);
            check($sformatf("table[%0d]", i), vt[i].cw, vt[i].step, vt[i].halted);
            check_onehot($sformatf("table_bus[%0d]", i));
        end

        // Parked in HALT: ena toggling must not wake it
        for (int i = 0; i < 20; i++) begin
            apply(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1, 1);
            check($sformatf("halt_hold[%0d]", i), '0, 4, 1);
        end
        apply(1, 1, 4'h1, 0, 0);
        check("halt_rst_cycle", '0, 4, 1);
        apply(0, 1, 4'h1, 0, 0);
        check("halt_exit_t0", F_T0, 0, 0);

        // Random run against the instruction-level model
        begin
            int         t;
            bit         hlt;
            logic [3:0] cur_op;
            logic       r, e, c, z;
            cw_t        ecw;
            t = 0; hlt = 1'b0; cur_op = 4'h0;
            for (int i = 0; i < 4000; i++) begin
                r = (i == 0) || ($urandom_range(0, 49) == 0);
                e = ($urandom_range(0, 7) != 0);
                c = 1'($urandom_range(0, 1));
                z = 1'($urandom_range(0, 1));
                if (t == 0) cur_op = 4'($urandom_range(0, 15));
                apply(r, e, cur_op, c, z);
                ecw = (r || hlt || !e) ? cw_t'(0) : ref_mask(cur_op, t, c, z);
                if (i > 0)
                    check($sformatf("rand[%0d] op=%h t=%0d", i, cur_op, t), ecw,
                          hlt ? 3'd4 : 3'(t), hlt);
                check_onehot($sformatf("rand_bus[%0d]", i));
                if (r) begin
                    t = 0; hlt = 1'b0;
                end else if (!hlt && e) begin
                    if (t == 2 && cur_op == 4'hF) hlt = 1'b1;
                    else if (t + 1 == ins_len(cur_op)) t = 0;
                    else t = t + 1;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
